// File: rtl/game_pkg.sv
// Shared types and widths for the game sequencing logic: round states,
// datapath widths and a saturating score increment.
package game_pkg;

  typedef enum logic [2:0] {
    GAME_OVER = 3'd0,
    IDLE      = 3'd1,
    APPROACH  = 3'd2,
    CHECK     = 3'd3
  } game_state_t;

  localparam int DEPTH_W   = 8;
  localparam int COLL_W    = 20;
  localparam int WALL_ID_W = 3;
  localparam int SCORE_W   = 8;
  localparam int LIVES_W   = 2;

  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/collision_accumulator.sv
// Saturating collision-pixel counter with synchronous clear and a
// strictly-greater-than threshold flag.
module collision_accumulator
  import game_pkg::*;
#(
  parameter int THRESHOLD = 2000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic qualify_in,
  output logic over_out
);

  logic [COLL_W-1:0] count_reg;

  // Clear wins over qualify so the pixel in the entering cycle is dropped.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_reg <= '0;
    end else if (clear_in) begin
      count_reg <= '0;
    end else if (qualify_in && (count_reg != {COLL_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign over_out = (count_reg > COLL_W'(THRESHOLD));

endmodule

// File: rtl/game_state_controller.sv
// Round sequencer: advances the approaching wall per frame tick, evaluates
// collisions at the player's plane, and tracks score, lives and wall index.
module game_state_controller
  import game_pkg::*;
#(
  parameter int MAX_WALL_DEPTH      = 75,
  parameter int GOAL_DEPTH          = 60,
  parameter int FRAMES_PER_STEP     = 4,
  parameter int COLLISION_THRESHOLD = 2000,
  parameter int NUM_LIVES           = 3,
  parameter int NUM_WALLS           = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_tick_in,
  input  logic                 pixel_valid_in,
  input  logic                 is_collision_in,
  input  logic                 start_in,
  output logic [2:0]           game_state_out,
  output logic [DEPTH_W-1:0]   wall_depth_out,
  output logic [WALL_ID_W-1:0] wall_id_out,
  output logic [SCORE_W-1:0]   score_out,
  output logic [LIVES_W-1:0]   lives_out,
  output logic                 new_wall_out
);

  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [DEPTH_W-1:0]   DEPTH_MAX = DEPTH_W'(MAX_WALL_DEPTH);
  localparam logic [DEPTH_W-1:0]   DEPTH_GOAL = DEPTH_W'(GOAL_DEPTH);
  localparam logic [WALL_ID_W-1:0] WALL_LAST = WALL_ID_W'(NUM_WALLS - 1);
  localparam logic [LIVES_W-1:0]   LIVES_INIT = LIVES_W'(NUM_LIVES);

  game_state_t          state_reg, state_next;
  logic [DEPTH_W-1:0]   depth_reg, depth_next;
  logic [WALL_ID_W-1:0] wall_id_reg, wall_id_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic [LIVES_W-1:0]   lives_reg, lives_next;
  logic [STEP_W-1:0]    step_reg, step_next;
  logic                 new_wall_reg, new_wall_next;
  logic                 start_reg;

  logic start_edge;
  logic coll_clear;
  logic coll_qualify;
  logic coll_over;
  logic load_wall;

  assign start_edge = start_in && !start_reg;

  // Tick cycles never count, so the evaluating tick's pixel is excluded.
  assign coll_qualify = (state_reg == CHECK) && pixel_valid_in && is_collision_in
                        && !frame_tick_in;

  collision_accumulator #(
    .THRESHOLD (COLLISION_THRESHOLD)
  ) u_collision_accumulator (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_in   (coll_clear),
    .qualify_in (coll_qualify),
    .over_out   (coll_over)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      depth_reg    <= DEPTH_MAX;
      wall_id_reg  <= '0;
      score_reg    <= '0;
      lives_reg    <= LIVES_INIT;
      step_reg     <= '0;
      new_wall_reg <= 1'b0;
      start_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      depth_reg    <= depth_next;
      wall_id_reg  <= wall_id_next;
      score_reg    <= score_next;
      lives_reg    <= lives_next;
      step_reg     <= step_next;
      new_wall_reg <= new_wall_next;
      start_reg    <= start_in;
    end
  end

  always_comb begin
    state_next    = state_reg;
    depth_next    = depth_reg;
    wall_id_next  = wall_id_reg;
    score_next    = score_reg;
    lives_next    = lives_reg;
    step_next     = step_reg;
    new_wall_next = 1'b0;
    coll_clear    = 1'b0;
    load_wall     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next = APPROACH;
          step_next  = '0;
          depth_next = DEPTH_MAX;
        end
      end

      APPROACH: begin
        if (frame_tick_in) begin
          if (step_reg == STEP_LAST) begin
            step_next  = '0;
            depth_next = depth_reg - 1'b1;
            if (depth_next == DEPTH_GOAL) begin
              state_next = CHECK;
              coll_clear = 1'b1;
            end
          end else begin
            step_next = step_reg + 1'b1;
          end
        end
      end

      CHECK: begin
        if (frame_tick_in) begin
          if (coll_over) begin
            if (lives_reg == 2'd1) begin
              lives_next = '0;
              state_next = GAME_OVER;
            end else begin
              lives_next = lives_reg - 1'b1;
              load_wall  = 1'b1;
            end
          end else begin
            score_next = sat_inc_score(score_reg);
            load_wall  = 1'b1;
          end
        end
        if (load_wall) begin
          state_next    = APPROACH;
          depth_next    = DEPTH_MAX;
          wall_id_next  = (wall_id_reg == WALL_LAST) ? '0 : wall_id_reg + 1'b1;
          new_wall_next = 1'b1;
          step_next     = '0;
        end
      end

      GAME_OVER: begin
        if (start_edge) begin
          state_next   = IDLE;
          score_next   = '0;
          lives_next   = LIVES_INIT;
          wall_id_next = '0;
          depth_next   = DEPTH_MAX;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign game_state_out = state_reg;
  assign wall_depth_out = depth_reg;
  assign wall_id_out    = wall_id_reg;
  assign score_out      = score_reg;
  assign lives_out      = lives_reg;
  assign new_wall_out   = new_wall_reg;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: approach timing, wall scoring,
// life loss, masked collisions, restart handling and asynchronous reset.
module tb_game_state_controller;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       frame_tick_in;
  logic       pixel_valid_in;
  logic       is_collision_in;
  logic       start_in;
  logic [2:0] game_state_out;
  logic [7:0] wall_depth_out;
  logic [2:0] wall_id_out;
  logic [7:0] score_out;
  logic [1:0] lives_out;
  logic       new_wall_out;

  int checks = 0;
  int failures = 0;

  game_state_controller dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .frame_tick_in   (frame_tick_in),
    .pixel_valid_in  (pixel_valid_in),
    .is_collision_in (is_collision_in),
    .start_in        (start_in),
    .game_state_out  (game_state_out),
    .wall_depth_out  (wall_depth_out),
    .wall_id_out     (wall_id_out),
    .score_out       (score_out),
    .lives_out       (lives_out),
    .new_wall_out    (new_wall_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Entered at a falling edge; inputs are held across one rising edge and
  // outputs are observed at the following falling edge.
  task automatic cycle(input logic ft, input logic pv, input logic ic);
    frame_tick_in   = ft;
    pixel_valid_in  = pv;
    is_collision_in = ic;
    @(negedge clk_in);
    frame_tick_in   = 1'b0;
    pixel_valid_in  = 1'b0;
    is_collision_in = 1'b0;
  endtask

  task automatic run_to_check(input logic last_pv, input logic last_ic);
    for (int i = 1; i <= 60; i++) cycle(1'b1, (i == 60) ? last_pv : 1'b0, (i == 60) ? last_ic : 1'b0);
    checks++; if (game_state_out !== 3'd3) begin failures++; $display("FAIL reach_check state got=%0d exp=3", game_state_out); end
    checks++; if (wall_depth_out !== 8'd60) begin failures++; $display("FAIL reach_check depth got=%0d exp=60", wall_depth_out); end
  endtask

  task automatic test_reset;
    checks++; if (game_state_out !== 3'd1) begin failures++; $display("FAIL reset_state got=%0d exp=1", game_state_out); end
    checks++; if (wall_depth_out !== 8'd75) begin failures++; $display("FAIL reset_depth got=%0d exp=75", wall_depth_out); end
    checks++; if (wall_id_out !== 3'd0) begin failures++; $display("FAIL reset_wall_id got=%0d exp=0", wall_id_out); end
    checks++; if (score_out !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score_out); end
    checks++; if (lives_out !== 2'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives_out); end
    checks++; if (new_wall_out !== 1'b0) begin failures++; $display("FAIL reset_new_wall got=%0d exp=0", new_wall_out); end
    cycle(1'b1, 1'b1, 1'b1);
    checks++; if (game_state_out !== 3'd1) begin failures++; $display("FAIL idle_tick_state got=%0d exp=1", game_state_out); end
    $display("reset: state=%0d depth=%0d lives=%0d", game_state_out, wall_depth_out, lives_out);
  endtask

  task automatic test_approach;
    logic [7:0] exp_depth;
    start_in = 1'b1; cycle(1'b0, 1'b0, 1'b0); start_in = 1'b0; cycle(1'b0, 1'b0, 1'b0);
    checks++; if (game_state_out !== 3'd2) begin failures++; $display("FAIL start_state got=%0d exp=2", game_state_out); end
    checks++; if (wall_depth_out !== 8'd75) begin failures++; $display("FAIL start_depth got=%0d exp=75", wall_depth_out); end
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      exp_depth = 8'(75 - i / 4);
      checks++; if (wall_depth_out !== exp_depth) begin failures++; $display("FAIL approach_depth tick=%0d got=%0d exp=%0d", i, wall_depth_out, exp_depth); end
      if (i == 30) begin
        start_in = 1'b1; cycle(1'b0, 1'b0, 1'b0); start_in = 1'b0; cycle(1'b0, 1'b0, 1'b0);
        checks++; if (game_state_out !== 3'd2) begin failures++; $display("FAIL approach_start_ignored got=%0d exp=2", game_state_out); end
        checks++; if (wall_depth_out !== 8'd68) begin failures++; $display("FAIL approach_start_depth got=%0d exp=68", wall_depth_out); end
      end
      if (i == 59) begin
        checks++; if (game_state_out !== 3'd2) begin failures++; $display("FAIL approach_tick59_state got=%0d exp=2", game_state_out); end
      end
    end
    checks++; if (game_state_out !== 3'd3) begin failures++; $display("FAIL approach_tick60_state got=%0d exp=3", game_state_out); end
    $display("approach: 60 ticks state=%0d depth=%0d", game_state_out, wall_depth_out);
  endtask

  task automatic test_check_pass;
    repeat (10) cycle(1'b0, 1'b0, 1'b1);
    repeat (2000) cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    checks++; if (score_out !== 8'd1) begin failures++; $display("FAIL pass_score got=%0d exp=1", score_out); end
    checks++; if (lives_out !== 2'd3) begin failures++; $display("FAIL pass_lives got=%0d exp=3", lives_out); end
    checks++; if (wall_depth_out !== 8'd75) begin failures++; $display("FAIL pass_depth got=%0d exp=75", wall_depth_out); end
    checks++; if (wall_id_out !== 3'd1) begin failures++; $display("FAIL pass_wall_id got=%0d exp=1", wall_id_out); end
    checks++; if (game_state_out !== 3'd2) begin failures++; $display("FAIL pass_state got=%0d exp=2", game_state_out); end
    checks++; if (new_wall_out !== 1'b1) begin failures++; $display("FAIL pass_new_wall got=%0d exp=1", new_wall_out); end
    cycle(1'b0, 1'b0, 1'b0);
    checks++; if (new_wall_out !== 1'b0) begin failures++; $display("FAIL pass_new_wall_drop got=%0d exp=0", new_wall_out); end
    $display("wall pass: 2000 pixels score=%0d lives=%0d id=%0d", score_out, lives_out, wall_id_out);
  endtask

  task automatic test_masked;
    run_to_check(1'b1, 1'b1);
    repeat (2500) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    checks++; if (score_out !== 8'd2) begin failures++; $display("FAIL masked_score got=%0d exp=2", score_out); end
    checks++; if (lives_out !== 2'd3) begin failures++; $display("FAIL masked_lives got=%0d exp=3", lives_out); end
    checks++; if (wall_id_out !== 3'd2) begin failures++; $display("FAIL masked_wall_id got=%0d exp=2", wall_id_out); end
    checks++; if (new_wall_out !== 1'b1) begin failures++; $display("FAIL masked_new_wall got=%0d exp=1", new_wall_out); end
    $display("wall masked: score=%0d lives=%0d id=%0d", score_out, lives_out, wall_id_out);
  endtask

  task automatic test_fail_three;
    logic [1:0] exp_lives;
    for (int w = 1; w <= 3; w++) begin
      run_to_check(1'b0, 1'b0);
      repeat (2001) cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      exp_lives = 2'(3 - w);
      checks++; if (lives_out !== exp_lives) begin failures++; $display("FAIL fail_lives wall=%0d got=%0d exp=%0d", w, lives_out, exp_lives); end
      checks++; if (score_out !== 8'd2) begin failures++; $display("FAIL fail_score wall=%0d got=%0d exp=2", w, score_out); end
      if (w < 3) begin
        checks++; if (game_state_out !== 3'd2) begin failures++; $display("FAIL fail_state wall=%0d got=%0d exp=2", w, game_state_out); end
        checks++; if (new_wall_out !== 1'b1) begin failures++; $display("FAIL fail_new_wall wall=%0d got=%0d exp=1", w, new_wall_out); end
        checks++; if (wall_id_out !== 3'(2 + w)) begin failures++; $display("FAIL fail_wall_id wall=%0d got=%0d exp=%0d", w, wall_id_out, 2 + w); end
      end else begin
        checks++; if (game_state_out !== 3'd0) begin failures++; $display("FAIL gameover_state got=%0d exp=0", game_state_out); end
        checks++; if (new_wall_out !== 1'b0) begin failures++; $display("FAIL gameover_new_wall got=%0d exp=0", new_wall_out); end
        checks++; if (wall_id_out !== 3'd4) begin failures++; $display("FAIL gameover_wall_id got=%0d exp=4", wall_id_out); end
        checks++; if (wall_depth_out !== 8'd60) begin failures++; $display("FAIL gameover_depth got=%0d exp=60", wall_depth_out); end
      end
      $display("wall fail %0d: 2001 pixels lives=%0d state=%0d", w, lives_out, game_state_out);
    end
    repeat (3) cycle(1'b1, 1'b1, 1'b1);
    checks++; if (game_state_out !== 3'd0) begin failures++; $display("FAIL gameover_hold_state got=%0d exp=0", game_state_out); end
    checks++; if (lives_out !== 2'd0) begin failures++; $display("FAIL gameover_hold_lives got=%0d exp=0", lives_out); end
  endtask

  task automatic test_restart;
    start_in = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    checks++; if (game_state_out !== 3'd1) begin failures++; $display("FAIL restart_state got=%0d exp=1", game_state_out); end
    checks++; if (score_out !== 8'd0) begin failures++; $display("FAIL restart_score got=%0d exp=0", score_out); end
    checks++; if (lives_out !== 2'd3) begin failures++; $display("FAIL restart_lives got=%0d exp=3", lives_out); end
    checks++; if (wall_id_out !== 3'd0) begin failures++; $display("FAIL restart_wall_id got=%0d exp=0", wall_id_out); end
    checks++; if (wall_depth_out !== 8'd75) begin failures++; $display("FAIL restart_depth got=%0d exp=75", wall_depth_out); end
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    checks++; if (game_state_out !== 3'd1) begin failures++; $display("FAIL restart_held_state got=%0d exp=1", game_state_out); end
    start_in = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    start_in = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    start_in = 1'b0;
    checks++; if (game_state_out !== 3'd2) begin failures++; $display("FAIL repress_state got=%0d exp=2", game_state_out); end
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wall_depth_out !== 8'd75) begin failures++; $display("FAIL start_tick_not_step got=%0d exp=75", wall_depth_out); end
    cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wall_depth_out !== 8'd74) begin failures++; $display("FAIL first_step_depth got=%0d exp=74", wall_depth_out); end
    $display("restart: state=%0d depth=%0d score=%0d lives=%0d", game_state_out, wall_depth_out, score_out, lives_out);
  endtask

  task automatic test_async_reset;
    repeat (56) cycle(1'b1, 1'b0, 1'b0);
    checks++; if (game_state_out !== 3'd3) begin failures++; $display("FAIL prereset_state got=%0d exp=3", game_state_out); end
    repeat (50) cycle(1'b0, 1'b1, 1'b1);
    #2 rst_in = 1'b1;
    #1;
    checks++; if (game_state_out !== 3'd1) begin failures++; $display("FAIL async_state got=%0d exp=1", game_state_out); end
    checks++; if (wall_depth_out !== 8'd75) begin failures++; $display("FAIL async_depth got=%0d exp=75", wall_depth_out); end
    checks++; if (wall_id_out !== 3'd0) begin failures++; $display("FAIL async_wall_id got=%0d exp=0", wall_id_out); end
    checks++; if (score_out !== 8'd0) begin failures++; $display("FAIL async_score got=%0d exp=0", score_out); end
    checks++; if (lives_out !== 2'd3) begin failures++; $display("FAIL async_lives got=%0d exp=3", lives_out); end
    checks++; if (new_wall_out !== 1'b0) begin failures++; $display("FAIL async_new_wall got=%0d exp=0", new_wall_out); end
    @(negedge clk_in);
    rst_in = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    checks++; if (game_state_out !== 3'd1) begin failures++; $display("FAIL postreset_state got=%0d exp=1", game_state_out); end
    $display("async reset: state=%0d depth=%0d", game_state_out, wall_depth_out);
  endtask

  initial begin
    rst_in          = 1'b1;
    frame_tick_in   = 1'b0;
    pixel_valid_in  = 1'b0;
    is_collision_in = 1'b0;
    start_in        = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    test_reset();
    test_approach();
    test_check_pass();
    test_masked();
    test_fail_three();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
